pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Next-generation control path for the 5-stage pipelined RV32I core.
- Takes the decoded control bundle of the instruction in ID and registers it into an ID/EX control register.
- Detects load-use hazards (stall plus bubble), resolves branches and jumps in EX (redirect plus flush), and generates EX-stage forwarding selects.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- REG_ADDR_WIDTH, 5: register index width.
- ALU_CTRL_WIDTH, 4: ALU control field width.
- MEM_CTRL_WIDTH, 3: memory access-size control width.
- CNT_WIDTH, 16: width of each performance counter.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iHold  in  1  external freeze (memory wait); holds all state.
- iIdValid  in  1  the ID-stage instruction is valid.
- iIdRs1, iIdRs2, iIdRd  in  REG_ADDR_WIDTH  ID source and destination indices.
- iIdUsesRs1, iIdUsesRs2  in  1  the ID instruction reads rs1 / rs2.
- iIdAluCtrl  in  ALU_CTRL_WIDTH  decoded ALU control.
- iIdMemCtrl  in  MEM_CTRL_WIDTH  decoded access size and sign.
- iIdAluSrc, iIdResultSrc, iIdMemRead, iIdMemWrite, iIdRegWrite, iIdBranch, iIdBranchInv, iIdJump  in  1 each  decoded controls.
- iExZero  in  1  ALU zero flag of the EX instruction.
- iMemRd  in  REG_ADDR_WIDTH  EX/MEM destination register.
- iMemRegWrite  in  1  EX/MEM write enable.
- iWbRd  in  REG_ADDR_WIDTH  MEM/WB destination register.
- iWbRegWrite  in  1  MEM/WB write enable.
- oEx*  out  matching width  registered copies of every iId* control plus Rs1, Rs2, Rd.
- oExValid  out  1  the EX slot holds a real instruction.
- oStall  out  1  hold PC and IF/ID this cycle.
- oFlush  out  1  squash IF/ID this cycle.
- oPCSrc  out  1  select the branch/jump target.
- oFwdA, oFwdB  out  2  forwarding selects: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- oStallCount, oFlushCount  out  CNT_WIDTH  saturating event counters.

Behaviour:
- Reset (asynchronous, iRst=1): all oEx* and oExValid are 0; counters are 0. Combinational outputs then evaluate to 0.
- An invalid EX slot (oExValid=0) has all of its write enables, Branch and Jump treated as 0.
- Taken branch: taken = oExValid & (oExJump | (oExBranch & (iExZero ^ oExBranchInv))).
  - oPCSrc = oFlush = taken & ~iHold.
  - Redirect latency is 1 cycle: the target is fetched on the next edge.
- Load-use hazard: loaduse = iIdValid & oExValid & oExMemRead & (oExRd≠0) & ((iIdUsesRs1 & iIdRs1==oExRd) | (iIdUsesRs2 & iIdRs2==oExRd)).
  - oStall = loaduse & ~taken & ~iHold. A flush overrides a stall.
- ID/EX register update on each edge, in priority order:
  - iHold=1: hold every field.
  - taken=1: load a bubble (oExValid=0, all enables 0, other fields don't-care and zeroed).
  - loaduse=1: load a bubble.
  - Otherwise: capture the iId* fields, with oExValid=iIdValid.
  - Stall penalty is exactly 1 bubble. Flush penalty is 2 cycles: IF/ID is squashed and the ID/EX bubble is inserted.
- Forwarding, combinational on the oEx fields:
  - oFwdA = 10 if iMemRegWrite & iMemRd≠0 & iMemRd==oExRs1.
  - Otherwise oFwdA = 01 if iWbRegWrite & iWbRd≠0 & iWbRd==oExRs1.
  - Otherwise oFwdA = 00.
  - oFwdB is the same with oExRs2. EX/MEM wins when both stages match.
  - Register x0 never forwards.
  - Forwarding is computed regardless of oExValid; a bubble's selects are don't-care.
- Counters:
  - oStallCount increments on each edge where oStall=1.
  - oFlushCount increments on each edge where oFlush=1.
  - Both saturate at 2^CNT_WIDTH−1 with no wrap.
  - Both hold while iHold=1.
- Reset mid-stall or mid-flush: everything clears immediately. The first post-reset edge captures ID normally.
- Simultaneous taken branch and load-use: a flush only. The stall counter does not increment.

Test Plan:
- Reset: assert iRst asynchronously between edges while ID/EX is full -> oExValid=0, oExRegWrite=0, and both counters are 0 before the next edge.
- Load-use: EX lw x5 (MemRead=1, Rd=5); ID add x6,x5,x7 (UsesRs1, Rs1=5) -> oStall=1 for one cycle, next oExValid=0, oStallCount=1; the following cycle the add enters EX with oFwdA=01 when iWbRd=5 and iWbRegWrite=1.
- Branch taken: EX beq with oExBranch=1, BranchInv=0, iExZero=1 -> oPCSrc=1, oFlush=1, next oExValid=0, oFlushCount=1. With iExZero=0 -> no flush.
- Flush beats stall, and hold: apply the taken branch and a matching load-use together -> oFlush=1, oStall=0, oStallCount unchanged. Then assert iHold -> oPCSrc=0 and the ID/EX fields are frozen.
- Forwarding priority: oExRs1=3, iMemRd=3, iWbRd=3, both write enables 1 -> oFwdA=10. With iMemRd=0 and oExRs1=0 -> oFwdA=00.
- Saturation: CNT_WIDTH=2, five consecutive load-use stalls -> oStallCount reads 1,2,3,3,3.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// ID/EX control register plus hazard, branch-redirect and forwarding control for the
// 5-stage RV32I pipeline, with saturating stall/flush event counters.
module pipelined_control_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int MEM_CTRL_WIDTH = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iHold,
    input  logic                      iIdValid,
    input  logic [REG_ADDR_WIDTH-1:0] iIdRs1,
    input  logic [REG_ADDR_WIDTH-1:0] iIdRs2,
    input  logic [REG_ADDR_WIDTH-1:0] iIdRd,
    input  logic                      iIdUsesRs1,
    input  logic                      iIdUsesRs2,
    input  logic [ALU_CTRL_WIDTH-1:0] iIdAluCtrl,
    input  logic [MEM_CTRL_WIDTH-1:0] iIdMemCtrl,
    input  logic                      iIdAluSrc,
    input  logic                      iIdResultSrc,
    input  logic                      iIdMemRead,
    input  logic                      iIdMemWrite,
    input  logic                      iIdRegWrite,
    input  logic                      iIdBranch,
    input  logic                      iIdBranchInv,
    input  logic                      iIdJump,
    input  logic                      iExZero,
    input  logic [REG_ADDR_WIDTH-1:0] iMemRd,
    input  logic                      iMemRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] iWbRd,
    input  logic                      iWbRegWrite,
    output logic                      oExValid,
    output logic [REG_ADDR_WIDTH-1:0] oExRs1,
    output logic [REG_ADDR_WIDTH-1:0] oExRs2,
    output logic [REG_ADDR_WIDTH-1:0] oExRd,
    output logic                      oExUsesRs1,
    output logic                      oExUsesRs2,
    output logic [ALU_CTRL_WIDTH-1:0] oExAluCtrl,
    output logic [MEM_CTRL_WIDTH-1:0] oExMemCtrl,
    output logic                      oExAluSrc,
    output logic                      oExResultSrc,
    output logic                      oExMemRead,
    output logic                      oExMemWrite,
    output logic                      oExRegWrite,
    output logic                      oExBranch,
    output logic                      oExBranchInv,
    output logic                      oExJump,
    output logic                      oStall,
    output logic                      oFlush,
    output logic                      oPCSrc,
    output logic [1:0]                oFwdA,
    output logic [1:0]                oFwdB,
    output logic [CNT_WIDTH-1:0]      oStallCount,
    output logic [CNT_WIDTH-1:0]      oFlushCount
);

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      uses_rs1;
        logic                      uses_rs2;
        logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
        logic [MEM_CTRL_WIDTH-1:0] mem_ctrl;
        logic                      alu_src;
        logic                      result_src;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
        logic                      branch;
        logic                      branch_inv;
        logic                      jump;
    } idex_t;

    idex_t                idex_q, idex_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 taken;
    logic                 loaduse;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd,
        input logic                      mem_we,
        input logic [REG_ADDR_WIDTH-1:0] wb_rd,
        input logic                      wb_we
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) return 2'b10;
        if (wb_we && (wb_rd != '0) && (wb_rd == rs))    return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        taken   = idex_q.valid & (idex_q.jump | (idex_q.branch & (iExZero ^ idex_q.branch_inv)));
        loaduse = iIdValid & idex_q.valid & idex_q.mem_read & (idex_q.rd != '0)
                & ((iIdUsesRs1 & (iIdRs1 == idex_q.rd)) | (iIdUsesRs2 & (iIdRs2 == idex_q.rd)));
        oPCSrc  = taken & ~iHold;
        oFlush  = taken & ~iHold;
        oStall  = loaduse & ~taken & ~iHold;
        oFwdA   = fwd_sel(idex_q.rs1, iMemRd, iMemRegWrite, iWbRd, iWbRegWrite);
        oFwdB   = fwd_sel(idex_q.rs2, iMemRd, iMemRegWrite, iWbRd, iWbRegWrite);
    end

    // Enables are masked with the valid bit on capture so an empty slot can never act.
    always_comb begin
        idex_d = idex_q;
        if (!iHold) begin
            if (taken || loaduse) begin
                idex_d = '0;
            end else begin
                idex_d.valid      = iIdValid;
                idex_d.rs1        = iIdRs1;
                idex_d.rs2        = iIdRs2;
                idex_d.rd         = iIdRd;
                idex_d.uses_rs1   = iIdUsesRs1;
                idex_d.uses_rs2   = iIdUsesRs2;
                idex_d.alu_ctrl   = iIdAluCtrl;
                idex_d.mem_ctrl   = iIdMemCtrl;
                idex_d.alu_src    = iIdAluSrc;
                idex_d.result_src = iIdResultSrc;
                idex_d.mem_read   = iIdMemRead & iIdValid;
                idex_d.mem_write  = iIdMemWrite & iIdValid;
                idex_d.reg_write  = iIdRegWrite & iIdValid;
                idex_d.branch     = iIdBranch & iIdValid;
                idex_d.branch_inv = iIdBranchInv;
                idex_d.jump       = iIdJump & iIdValid;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (oStall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (oFlush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign oExValid     = idex_q.valid;
    assign oExRs1       = idex_q.rs1;
    assign oExRs2       = idex_q.rs2;
    assign oExRd        = idex_q.rd;
    assign oExUsesRs1   = idex_q.uses_rs1;
    assign oExUsesRs2   = idex_q.uses_rs2;
    assign oExAluCtrl   = idex_q.alu_ctrl;
    assign oExMemCtrl   = idex_q.mem_ctrl;
    assign oExAluSrc    = idex_q.alu_src;
    assign oExResultSrc = idex_q.result_src;
    assign oExMemRead   = idex_q.mem_read;
    assign oExMemWrite  = idex_q.mem_write;
    assign oExRegWrite  = idex_q.reg_write;
    assign oExBranch    = idex_q.branch;
    assign oExBranchInv = idex_q.branch_inv;
    assign oExJump      = idex_q.jump;
    assign oStallCount  = stall_cnt_q;
    assign oFlushCount  = flush_cnt_q;

endmodule
